// File: rtl/fifo_uart_pkg.sv
// Shared types and frame constants for the FIFO-fed UART transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional parity bit controlled by macro FIFO_UART_TX_PARITY_EN.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_STOP_BITS  = 1;

  // Start bit + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_width, input int stop_bits);
    return 1 + data_width + PARITY_BITS + stop_bits;
  endfunction

  localparam int FRAME_BITS = frame_bits(DEF_DATA_WIDTH, DEF_STOP_BITS);

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: bit_tick is high in the last cycle of each CLKS_PER_BIT period.
// Latency: tick after CLKS_PER_BIT cycles from restart; restart clears the count.
// Backpressure: none; free-running between restarts.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == LAST);

  // Count 0..CLKS_PER_BIT-1, wrapping on the terminal value or on restart.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || bit_tick) begin
      cnt_d = '0;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte per frame from a synchronous FIFO and sends it as an 8N1/8N2 UART frame.
// Latency: pop in cycle N, start bit on tx from N+2; period 2 + CLKS_PER_BIT*FRAME_BITS.
// Backpressure: pops only in IDLE with enable=1 and FIFO non-empty; FIFO_UART_TX_PARITY_EN adds even parity.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  bit_tick;
  logic                  pop;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  // Reset gates the pop so the FIFO is never read while held in reset.
  assign pop        = reset && (state_q == IDLE) && enable && !fifo_empty;
  assign fifo_rd_en = pop;
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;

  // Every state entry starts a fresh bit period.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (state_d != state_q),
    .bit_tick (bit_tick)
  );

  // Next-state, shift register, bit counter and frame_done pulse.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    frame_done = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) state_d = FETCH;
      end
      FETCH: begin
        shreg_d = fifo_data;
        bit_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^fifo_data;
`endif
        state_d = START;
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_q == LAST_STOP) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the next cycle, taken from the next state so tx is a clean flop output.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and line registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4, STOP_BITS=1 and a behavioural FIFO.
// Latency: frame of 42 cycles (46 with FIFO_UART_TX_PARITY_EN) from pop to return to IDLE.
// Backpressure: FIFO model supplies data one cycle after fifo_rd_en.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME = 46;
`else
  localparam int FRAME = 42;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en, tx, busy, frame_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH   (8),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  logic [7:0] mem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int cyc = 0;
  int pops = 0;
  int dones = 0;
  int bad_pop = 0;
  int asserts = 0;
  int fails = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // Behavioural FIFO read port plus event counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      pops      <= pops + 1;
      if (fifo_empty) bad_pop <= bad_pop + 1;
    end
    if (frame_done) dones <= dones + 1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Expected line level k cycles after the pop cycle.
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    int p;
    if (k < 2) return 1'b1;
    p = (k - 2) / CPB;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (p == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_pop(output int n);
    int t;
    t = 0;
    while (fifo_rd_en !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    chk("pop_seen", {31'd0, fifo_rd_en}, 32'd1);
    n = cyc;
  endtask

  // Walk one frame from the pop cycle (k=0) up to the first IDLE cycle (k=FRAME).
  task automatic frame_check(input logic [7:0] b, input int n, input int drop_k);
    int k;
    while (1) begin
      k = cyc - n;
      chk("tx", {31'd0, tx}, {31'd0, exp_tx(k, b)});
      chk("busy", {31'd0, busy}, {31'd0, (k >= 1 && k < FRAME)});
      chk("frame_done", {31'd0, frame_done}, {31'd0, (k == FRAME - 1)});
      if (k > 0 && k < FRAME) chk("rd_en_in_frame", {31'd0, fifo_rd_en}, 32'd0);
      if (k >= FRAME) break;
      if (k == drop_k) enable = 1'b0;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n2, p0, d0;

    // Reset held with a non-empty FIFO and enable high.
    reset  = 1'b0;
    enable = 1'b1;
    push(8'hA5);
    repeat (3) step();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, frame_done}, 32'd0);

    // Release: pop in the very first cycle, then a full 0xA5 frame.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rd_en_after_release", {31'd0, fifo_rd_en}, 32'd1);
    wait_pop(n);
    frame_check(8'hA5, n, -1);
    p0 = pops;
    repeat (20) step();
    chk("single_no_extra_pop", pops, p0);
    chk("single_idle_tx", {31'd0, tx}, 32'd1);

    // Back-to-back 0x01 then 0x80, then FIFO runs empty.
    p0 = pops;
    push(8'h01);
    push(8'h80);
    #1;
    wait_pop(n1);
    frame_check(8'h01, n1, -1);
    wait_pop(n2);
    chk("b2b_spacing", n2 - n1, FRAME);
    frame_check(8'h80, n2, -1);
    repeat (50) step();
    chk("b2b_pop_count", pops, p0 + 2);
    chk("b2b_idle_tx", {31'd0, tx}, 32'd1);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);

    // Gating: enable low with data waiting.
    enable = 1'b0;
    p0 = pops;
    d0 = dones;
    push(8'h33);
    push(8'h44);
    repeat (100) step();
    chk("gate_no_pop", pops, p0);
    chk("gate_busy", {31'd0, busy}, 32'd0);

    // Enable for one frame, drop it in the middle of DATA.
    enable = 1'b1;
    #1;
    wait_pop(n);
    frame_check(8'h33, n, 22);
    repeat (60) step();
    chk("drop_pop_count", pops, p0 + 1);
    chk("drop_done_count", dones, d0 + 1);
    chk("drop_busy", {31'd0, busy}, 32'd0);

    // Reset during bit 3 of 0x3C; next frame must carry 0x5A.
    wr_ptr = rd_ptr;
    push(8'h3C);
    push(8'h5A);
    enable = 1'b1;
    #1;
    wait_pop(n);
    while (cyc - n < 19) step();
    chk("mid_busy_before_reset", {31'd0, busy}, 32'd1);
    chk("mid_tx_bit3", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_reset_tx", {31'd0, tx}, 32'd1);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    repeat (3) step();
    chk("mid_reset_hold_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    wait_pop(n);
    frame_check(8'h5A, n, -1);

`ifdef FIFO_UART_TX_PARITY_EN
    // Even parity: 0xA5 -> 0, 0x07 -> 1, at k = 38..41.
    push(8'hA5);
    #1;
    wait_pop(n);
    while (cyc - n < 39) step();
    chk("parity_a5", {31'd0, tx}, 32'd0);
    frame_check(8'hA5, n, -1);
    push(8'h07);
    #1;
    wait_pop(n);
    while (cyc - n < 39) step();
    chk("parity_07", {31'd0, tx}, 32'd1);
    frame_check(8'h07, n, -1);
`endif

    chk("no_pop_while_empty", bad_pop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
